// File: rtl/i2c_slave_target.sv
// 7-bit-address I2C target with a pointer-addressed byte bank, oversampled by the core clock.
// Define I2C_SLV_FILTER_EN to add a 3-tap majority glitch filter on both bus lines.
module i2c_slave_target #(
  parameter logic [6:0] SLV_ADDR  = 7'h50,
  parameter int         DEPTH     = 16,
  parameter int         DATA_SIZE = 8,
  localparam int        PTR_W     = $clog2(DEPTH)
) (
  input  logic                 i2c_core_clk_i,
  input  logic                 reset_ni,
  input  logic                 scl_i,
  input  logic                 sda_i,
  output logic                 sda_oe_o,
  output logic                 busy_o,
  output logic                 addr_match_o,
  output logic                 reg_wr_o,
  output logic [PTR_W-1:0]     reg_addr_o,
  output logic [DATA_SIZE-1:0] reg_wdata_o,
  input  logic [PTR_W-1:0]     dbg_addr_i,
  output logic [DATA_SIZE-1:0] dbg_data_o
);

  typedef enum logic [2:0] {IDLE, ADDR, ACK_A, WR_BYTE, ACK_W, RD_BYTE, RACK, WAIT} state_t;

  state_t state_q, state_d;

  logic scl_s1, scl_s2, sda_s1, sda_s2, scl_prev, sda_prev, scl_ln, sda_ln;
  logic scl_rise, scl_fall, sda_rise, sda_fall, start_det, stop_det, byte_done;

  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_SIZE-1:0] shreg_q, shreg_d, txreg_q, txreg_d, wdata_q, wdata_d, byte_in;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic                 rw_q, rw_d, first_q, first_d, mack_q, mack_d;
  logic                 sda_oe_q, sda_oe_d, busy_q, busy_d, match_q, match_d, wr_q, wr_d;
  logic [DATA_SIZE-1:0] mem [DEPTH];

  // Synchronizers reset to the idle-high bus level so release from reset creates no edges.
  always_ff @(posedge i2c_core_clk_i) begin
    if (!reset_ni) begin
      {scl_s1, scl_s2, sda_s1, sda_s2, scl_prev, sda_prev} <= '1;
    end else begin
      scl_s1   <= scl_i;
      scl_s2   <= scl_s1;
      sda_s1   <= sda_i;
      sda_s2   <= sda_s1;
      scl_prev <= scl_ln;
      sda_prev <= sda_ln;
    end
  end

`ifdef I2C_SLV_FILTER_EN
  logic [1:0] scl_h, sda_h;
  logic       scl_flt, sda_flt;

  always_ff @(posedge i2c_core_clk_i) begin
    if (!reset_ni) begin
      scl_h   <= '1;
      sda_h   <= '1;
      scl_flt <= 1'b1;
      sda_flt <= 1'b1;
    end else begin
      scl_h   <= {scl_h[0], scl_s2};
      sda_h   <= {sda_h[0], sda_s2};
      scl_flt <= (scl_s2 & scl_h[0]) | (scl_s2 & scl_h[1]) | (scl_h[0] & scl_h[1]);
      sda_flt <= (sda_s2 & sda_h[0]) | (sda_s2 & sda_h[1]) | (sda_h[0] & sda_h[1]);
    end
  end

  assign scl_ln = scl_flt;
  assign sda_ln = sda_flt;
`else
  assign scl_ln = scl_s2;
  assign sda_ln = sda_s2;
`endif

  assign scl_rise  = scl_ln & ~scl_prev;
  assign scl_fall  = ~scl_ln & scl_prev;
  assign sda_rise  = sda_ln & ~sda_prev;
  assign sda_fall  = ~sda_ln & sda_prev;
  assign start_det = sda_fall & scl_ln;
  assign stop_det  = sda_rise & scl_ln;
  assign byte_in   = {shreg_q[DATA_SIZE-2:0], sda_ln};
  assign byte_done = scl_rise && (bit_cnt_q == 3'd0);

  always_ff @(posedge i2c_core_clk_i) begin
    if (!reset_ni) begin
      state_q   <= IDLE;
      bit_cnt_q <= 3'd7;
      shreg_q   <= '0;
      txreg_q   <= '0;
      wdata_q   <= '0;
      ptr_q     <= '0;
      rw_q      <= 1'b0;
      first_q   <= 1'b0;
      mack_q    <= 1'b0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      match_q   <= 1'b0;
      wr_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      txreg_q   <= txreg_d;
      wdata_q   <= wdata_d;
      ptr_q     <= ptr_d;
      rw_q      <= rw_d;
      first_q   <= first_d;
      mack_q    <= mack_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      match_q   <= match_d;
      wr_q      <= wr_d;
      if (wr_d) mem[ptr_q] <= wdata_d;
    end
  end

  // ACK_A/ACK_W span two SCL falls: the first drives ACK, the second (sda_oe already set) moves on.
  always_comb begin
    state_d = state_q;
    if (start_det) begin
      state_d = ADDR;
    end else if (stop_det) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        ADDR:    if (byte_done) state_d = (byte_in[DATA_SIZE-1:1] == SLV_ADDR) ? ACK_A : WAIT;
        ACK_A:   if (scl_fall && sda_oe_q) state_d = rw_q ? RD_BYTE : WR_BYTE;
        WR_BYTE: if (byte_done) state_d = ACK_W;
        ACK_W:   if (scl_fall && sda_oe_q) state_d = WR_BYTE;
        RD_BYTE: if (scl_fall && (bit_cnt_q == 3'd0)) state_d = RACK;
        RACK:    if (scl_fall) state_d = mack_q ? RD_BYTE : WAIT;
        default: state_d = state_q;
      endcase
    end
  end

  // The pointer advances the cycle after a write pulse so reg_addr_o shows the written index.
  always_comb begin
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    match_d   = match_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    txreg_d   = txreg_q;
    rw_d      = rw_q;
    first_d   = first_q;
    mack_d    = mack_q;
    wdata_d   = wdata_q;
    wr_d      = 1'b0;
    ptr_d     = wr_q ? ptr_q + 1'b1 : ptr_q;
    if (start_det) begin
      sda_oe_d  = 1'b0;
      busy_d    = 1'b1;
      match_d   = 1'b0;
      bit_cnt_d = 3'd7;
    end else if (stop_det) begin
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      match_d  = 1'b0;
    end else begin
      if (scl_rise && (state_q inside {ADDR, WR_BYTE})) begin
        shreg_d   = byte_in;
        bit_cnt_d = bit_cnt_q - 3'd1;
      end
      case (state_q)
        ADDR: if (byte_done) rw_d = byte_in[0];
        ACK_A: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
            match_d  = 1'b1;
          end else if (rw_q) begin
            txreg_d   = mem[ptr_q];
            sda_oe_d  = ~mem[ptr_q][DATA_SIZE-1];
            bit_cnt_d = 3'd7;
          end else begin
            sda_oe_d  = 1'b0;
            first_d   = 1'b1;
            bit_cnt_d = 3'd7;
          end
        end
        WR_BYTE: if (byte_done) begin
          if (first_q) begin
            ptr_d   = byte_in[PTR_W-1:0];
            first_d = 1'b0;
          end else begin
            wr_d    = 1'b1;
            wdata_d = byte_in;
          end
        end
        ACK_W: if (scl_fall) begin
          sda_oe_d = ~sda_oe_q;
          if (sda_oe_q) bit_cnt_d = 3'd7;
        end
        RD_BYTE: if (scl_fall) begin
          if (bit_cnt_q == 3'd0) begin
            sda_oe_d = 1'b0;
            ptr_d    = ptr_q + 1'b1;
          end else begin
            txreg_d   = txreg_q << 1;
            sda_oe_d  = ~txreg_q[DATA_SIZE-2];
            bit_cnt_d = bit_cnt_q - 3'd1;
          end
        end
        RACK: begin
          if (scl_rise) mack_d = ~sda_ln;
          if (scl_fall && mack_q) begin
            txreg_d   = mem[ptr_q];
            sda_oe_d  = ~mem[ptr_q][DATA_SIZE-1];
            bit_cnt_d = 3'd7;
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_oe_o     = sda_oe_q;
  assign busy_o       = busy_q;
  assign addr_match_o = match_q;
  assign reg_wr_o     = wr_q;
  assign reg_addr_o   = ptr_q;
  assign reg_wdata_o  = wdata_q;
  assign dbg_data_o   = mem[dbg_addr_i];

endmodule

// File: tb/tb_i2c_slave_target.sv
// Bench for i2c_slave_target: a bit-banged bus master plus a transaction-level bank/pointer model.
// Glitch expectations follow I2C_SLV_FILTER_EN, matching the build of the design.
`timescale 1ns/1ps
module tb_i2c_slave_target;
  localparam int Q     = 8;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset_ni = 1'b0;
  logic       scl_pin = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_oe, busy, addr_match, reg_wr;
  logic [3:0] reg_addr, dbg_addr;
  logic [7:0] reg_wdata, dbg_data;
  wire        sda_bus = sda_m & ~sda_oe;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  mem_model [DEPTH];
  int          ptr_model;
  logic [11:0] wr_seen [$];
  logic [11:0] wr_exp [$];

  always #5 clk = ~clk;

  i2c_slave_target dut (
    .i2c_core_clk_i(clk),
    .reset_ni(reset_ni),
    .scl_i(scl_pin),
    .sda_i(sda_bus),
    .sda_oe_o(sda_oe),
    .busy_o(busy),
    .addr_match_o(addr_match),
    .reg_wr_o(reg_wr),
    .reg_addr_o(reg_addr),
    .reg_wdata_o(reg_wdata),
    .dbg_addr_i(dbg_addr),
    .dbg_data_o(dbg_data)
  );

  always @(negedge clk) if (reg_wr) wr_seen.push_back({reg_addr, reg_wdata});

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One SCL clock: drive SDA while low, sample the wired bus mid-high, optionally glitch SCL low.
  task automatic applyStimulus(input logic b, input logic glitch, output logic r);
    sda_m = b;
    tick(Q);
    scl_pin = 1'b1;
    tick(Q / 2);
    r = sda_bus;
    if (glitch) begin
      scl_pin = 1'b0;
      tick(1);
      scl_pin = 1'b1;
    end
    tick(Q / 2);
    scl_pin = 1'b0;
    tick(Q);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    tick(Q);
    scl_pin = 1'b1;
    tick(Q);
    sda_m = 1'b0;
    tick(Q);
    scl_pin = 1'b0;
    tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    tick(Q);
    scl_pin = 1'b1;
    tick(Q);
    sda_m = 1'b1;
    tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, input int glitch_bit, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) applyStimulus(d[i], i == glitch_bit, r);
    applyStimulus(1'b1, 1'b0, r);
    ack = ~r;
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      applyStimulus(1'b1, 1'b0, r);
      d[i] = r;
    end
    applyStimulus(~master_ack, 1'b0, r);
  endtask

  task automatic do_write(input logic [7:0] p, input logic [7:0] data [$]);
    logic a;
    i2c_start();
    write_byte(8'hA0, -1, a);
    checkOutput("wr_addr_ack", a, 1);
    write_byte(p, -1, a);
    checkOutput("wr_ptr_ack", a, 1);
    ptr_model = p % DEPTH;
    foreach (data[i]) begin
      write_byte(data[i], -1, a);
      checkOutput("wr_data_ack", a, 1);
      mem_model[ptr_model] = data[i];
      wr_exp.push_back({4'(ptr_model), data[i]});
      ptr_model = (ptr_model + 1) % DEPTH;
    end
    i2c_stop();
    checkOutput("wr_busy_after_stop", busy, 0);
  endtask

  task automatic do_read(input logic set_ptr, input logic [7:0] p, input int n);
    logic       a;
    logic [7:0] d;
    i2c_start();
    if (set_ptr) begin
      write_byte(8'hA0, -1, a);
      checkOutput("rd_waddr_ack", a, 1);
      write_byte(p, -1, a);
      checkOutput("rd_ptr_ack", a, 1);
      ptr_model = p % DEPTH;
      i2c_start();
    end
    write_byte(8'hA1, -1, a);
    checkOutput("rd_addr_ack", a, 1);
    for (int i = 0; i < n; i++) begin
      read_byte(i != n - 1, d);
      checkOutput("rd_data", d, mem_model[ptr_model]);
      ptr_model = (ptr_model + 1) % DEPTH;
    end
    checkOutput("rd_release_after_nack", sda_oe, 0);
    i2c_stop();
    checkOutput("rd_ptr", reg_addr, ptr_model);
  endtask

  task automatic check_writes();
    logic [11:0] s, e;
    tick(2);
    checkOutput("wr_pulse_count", wr_seen.size(), wr_exp.size());
    while (wr_seen.size() > 0 && wr_exp.size() > 0) begin
      s = wr_seen.pop_front();
      e = wr_exp.pop_front();
      checkOutput("wr_pulse_addr_data", s, e);
    end
    wr_seen.delete();
    wr_exp.delete();
  endtask

  task automatic check_bank();
    for (int i = 0; i < DEPTH; i++) begin
      dbg_addr = i[3:0];
      #1;
      checkOutput("bank_byte", {i[3:0], dbg_data}, {i[3:0], mem_model[i]});
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem_model[i] = 8'h00;
    ptr_model = 0;
  endtask

  initial begin
    logic [7:0] q [$];
    logic [7:0] d;
    logic       a, r;
    int         n;

    $display("[TB] reset");
    model_reset();
    dbg_addr = 4'd0;
    tick(2);
    checkOutput("rst_sda_oe", sda_oe, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_match", addr_match, 0);
    checkOutput("rst_reg_wr", reg_wr, 0);
    checkOutput("rst_ptr", reg_addr, 0);
    check_bank();
    reset_ni = 1'b1;
    tick(4);

    $display("[TB] write 5A, C3 at pointer 3");
    q = '{8'h5A, 8'hC3};
    do_write(8'h03, q);
    check_writes();
    checkOutput("wr_ptr_after", reg_addr, 5);
    check_bank();

    $display("[TB] read with repeated start");
    do_read(1'b1, 8'h03, 2);
    checkOutput("rd_final_ptr", reg_addr, 5);

    $display("[TB] address mismatch");
    i2c_start();
    write_byte(8'hB0, -1, a);
    checkOutput("mm_addr_nack", a, 0);
    write_byte(8'h11, -1, a);
    checkOutput("mm_data_nack", a, 0);
    checkOutput("mm_busy", busy, 1);
    checkOutput("mm_match", addr_match, 0);
    i2c_stop();
    checkOutput("mm_busy_after_stop", busy, 0);
    check_writes();

    $display("[TB] pointer wrap");
    q = '{8'h11, 8'h22};
    do_write(8'h0F, q);
    check_writes();
    checkOutput("wrap_ptr", reg_addr, 1);
    check_bank();

    $display("[TB] randomized transactions");
    for (int k = 0; k < 4; k++) begin
      q.delete();
      n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) q.push_back(8'($urandom_range(0, 255)));
      do_write(8'($urandom_range(0, 255)), q);
      check_writes();
      do_read(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), $urandom_range(1, 4));
    end
    check_bank();

    $display("[TB] one-clock SCL glitch during a data byte");
    i2c_start();
    write_byte(8'hA0, -1, a);
    write_byte(8'h06, -1, a);
    ptr_model = 6;
    write_byte(8'hB4, 7, a);
    i2c_stop();
`ifdef I2C_SLV_FILTER_EN
    checkOutput("glitch_ack", a, 1);
    d = 8'hB4;
`else
    d = 8'hDA;
`endif
    mem_model[6] = d;
    wr_exp.push_back({4'd6, d});
    ptr_model = 7;
    check_writes();
    checkOutput("glitch_ptr", reg_addr, ptr_model);
    check_bank();

    $display("[TB] reset in the middle of a read byte");
    q = '{8'h22};
    do_write(8'h00, q);
    q.delete();
    do_write(8'h00, q);
    check_writes();
    i2c_start();
    write_byte(8'hA1, -1, a);
    checkOutput("mid_addr_ack", a, 1);
    checkOutput("mid_drive_msb", sda_oe, 1);
    checkOutput("mid_match", addr_match, 1);
    applyStimulus(1'b1, 1'b0, r);
    checkOutput("mid_bit7", r, 0);
    checkOutput("mid_drive_bit6", sda_oe, 1);
    reset_ni = 1'b0;
    tick(1);
    checkOutput("mid_rst_release", sda_oe, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_match", addr_match, 0);
    checkOutput("mid_rst_ptr", reg_addr, 0);
    reset_ni = 1'b1;
    model_reset();
    i2c_stop();
    check_bank();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
